// File: rtl/uart_autobaud_detect.sv
`timescale 1ns/1ps
// Measures a received 0x55 sync character on RX and derives the baud generator
// divisor (BAUD_VAL) plus an optional eighths fraction (BAUD_VAL_FRACTION).
module uart_autobaud_detect #(
  parameter bit BAUD_VAL_FRCTN_EN = 1'b0,
  parameter int TIMEOUT_W         = 21
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic        RX,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic [1:0]  ERR_CODE,
  output logic [12:0] BAUD_VAL,
  output logic [2:0]  BAUD_VAL_FRACTION
);

  localparam int NW = TIMEOUT_W + 1;
  localparam int XW = NW + 14;

  typedef enum logic [2:0] {IDLE, WAIT_HIGH, WAIT_EDGE, MEASURE, CALC, ERR} state_t;

  state_t state, state_next;
  logic [1:0] err_next;

  logic rx_ff1, rx_ff2, rx_sync, rx_prev, fe;
  logic [TIMEOUT_W-1:0] cnt, icnt, i1, n_meas, diff;
  logic [2:0] edge_no;
  logic [3:0] high_cnt;
  logic [NW-1:0] nr, quo;
  logic [XW-1:0] quo_x;
  logic mismatch, cnt_max, calc_slow, calc_big;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rx_ff1  <= 1'b0;
      rx_ff2  <= 1'b0;
      rx_sync <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      rx_ff1  <= RX;
      rx_ff2  <= rx_ff1;
      rx_sync <= rx_ff2;
      rx_prev <= rx_sync;
    end
  end

  assign fe = rx_prev & ~rx_sync;

  // Interval tolerance is one eighth of the first measured interval.
  always_comb begin
    diff      = (icnt >= i1) ? (icnt - i1) : (i1 - icnt);
    mismatch  = diff > (i1 >> 3);
    cnt_max   = &cnt;
    nr        = NW'(n_meas) + (BAUD_VAL_FRCTN_EN ? NW'(8) : NW'(64));
    quo       = nr >> 7;
    quo_x     = XW'(quo);
    calc_slow = (quo == '0);
    calc_big  = (quo_x > XW'(8192));
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    err_next   = 2'b00;
    case (state)
      IDLE:      if (START && !DONE) state_next = WAIT_HIGH;
      WAIT_HIGH: if (rx_sync && high_cnt == 4'd15) state_next = WAIT_EDGE;
      WAIT_EDGE: if (fe) state_next = MEASURE;
      MEASURE: begin
        if (fe) begin
          if (edge_no != 3'd1 && mismatch) begin
            state_next = ERR;
            err_next   = 2'b11;
          end else if (edge_no == 3'd4) begin
            state_next = CALC;
          end
        end else if (cnt_max) begin
          state_next = ERR;
          err_next   = 2'b10;
        end
      end
      CALC: begin
        if (calc_slow) begin
          state_next = ERR;
          err_next   = 2'b01;
        end else if (calc_big) begin
          state_next = ERR;
          err_next   = 2'b10;
        end else begin
          state_next = IDLE;
        end
      end
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The fifth falling edge closes eight bit times; its total count is the divisor basis.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      BUSY              <= 1'b0;
      DONE              <= 1'b0;
      ERROR             <= 1'b0;
      ERR_CODE          <= 2'b00;
      BAUD_VAL          <= '0;
      BAUD_VAL_FRACTION <= '0;
      cnt               <= '0;
      icnt              <= '0;
      i1                <= '0;
      n_meas            <= '0;
      edge_no           <= '0;
      high_cnt          <= '0;
    end else begin
      DONE  <= 1'b0;
      ERROR <= 1'b0;
      case (state)
        IDLE: begin
          if (state_next == WAIT_HIGH) begin
            BUSY     <= 1'b1;
            ERR_CODE <= 2'b00;
            high_cnt <= '0;
          end
        end
        WAIT_HIGH: high_cnt <= rx_sync ? high_cnt + 4'd1 : 4'd0;
        WAIT_EDGE: begin
          if (fe) begin
            cnt     <= TIMEOUT_W'(1);
            icnt    <= TIMEOUT_W'(1);
            edge_no <= 3'd1;
          end
        end
        MEASURE: begin
          cnt  <= cnt + TIMEOUT_W'(1);
          icnt <= fe ? TIMEOUT_W'(1) : icnt + TIMEOUT_W'(1);
          if (fe) begin
            edge_no <= edge_no + 3'd1;
            if (edge_no == 3'd1) i1 <= icnt;
            if (edge_no == 3'd4) n_meas <= cnt;
          end
        end
        CALC: begin
          if (state_next == IDLE) begin
            BAUD_VAL          <= 13'(quo - NW'(1));
            BAUD_VAL_FRACTION <= BAUD_VAL_FRCTN_EN ? nr[6:4] : 3'd0;
            DONE              <= 1'b1;
            BUSY              <= 1'b0;
          end
        end
        ERR: begin
          ERROR <= 1'b1;
          BUSY  <= 1'b0;
        end
        default: ;
      endcase
      if (state_next == ERR && state != ERR) ERR_CODE <= err_next;
    end
  end

endmodule
